// File: rtl/segment_scan_pkg.sv
// rtl/segment_scan_pkg.sv - shared types and helpers for the segment scan engine
package segment_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } scan_state_t;

    localparam int PWM_PERIOD = 16;

    function automatic int shift_len(input int seg_width, input int num_digits);
        return (seg_width > num_digits) ? seg_width : num_digits;
    endfunction

endpackage

// File: rtl/shift595_serializer.sv
// rtl/shift595_serializer.sv - shift-clock/latch timing shared by the segment and digit chains
module shift595_serializer #(
    parameter int SHIFT_LEN = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic shifting,
    input  logic latching,
    output logic srclk,
    output logic rclk,
    output logic shift_step,
    output logic shift_last,
    output logic latch_last
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;

    logic [PW-1:0] phase_q;
    logic [BW-1:0] bit_q;
    logic          high_q;
    logic          rclk_q;
    logic          phase_end;

    assign phase_end  = (phase_q == PW'(CLK_DIV - 1));
    assign shift_step = shifting && high_q && phase_end;
    assign shift_last = shift_step && (bit_q == '0);
    assign latch_last = latching && phase_end;
    assign srclk      = high_q;
    assign rclk       = rclk_q;

    // high_q is itself the shift clock, so srclk comes straight from a flop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            bit_q   <= '0;
            high_q  <= 1'b0;
            rclk_q  <= 1'b0;
        end else begin
            rclk_q <= shift_last || (latching && !latch_last);
            if (load) begin
                phase_q <= '0;
                bit_q   <= BW'(SHIFT_LEN - 1);
                high_q  <= 1'b0;
            end else if (shifting || latching) begin
                phase_q <= phase_end ? '0 : phase_q + PW'(1);
                if (shifting && phase_end) begin
                    high_q <= ~high_q;
                end
                if (shift_step && (bit_q != '0)) begin
                    bit_q <= bit_q - BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/segment_scan_driver.sv
// rtl/segment_scan_driver.sv - multiplexed 7-segment scan engine over two 595-style chains
// Optional brightness PWM during HOLD when SEGMENT_SCAN_PWM_EN is defined.
module segment_scan_driver
    import segment_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_WIDTH      = 8,
    parameter int CLK_DIV        = 4,
    parameter int DIGIT_HOLD     = 1024,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int COM_ACTIVE_LOW = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_DIGITS+1)-1:0]   wr_digit,
    input  logic [SEG_WIDTH-1:0]              wr_segments,
    input  logic [3:0]                        brightness,
    output logic                              seg_ser,
    output logic                              seg_srclk,
    output logic                              seg_rclk,
    output logic                              seg_oe,
    output logic                              com_ser,
    output logic                              com_srclk,
    output logic                              com_rclk,
    output logic                              com_oe,
    output logic                              frame_done
);

    localparam int SHIFT_LEN = shift_len(SEG_WIDTH, NUM_DIGITS);
    localparam int DW        = $clog2(NUM_DIGITS);
    localparam int WDW       = $clog2(NUM_DIGITS + 1);
    localparam int HW        = $clog2(DIGIT_HOLD);
    localparam logic [HW-1:0] H_LAST = HW'(DIGIT_HOLD - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

    scan_state_t            state_q, state_d;
    logic [HW-1:0]          h_q, h_d;
    logic [DW-1:0]          digit_q, digit_d;
    logic                   frame_q, frame_d;
    logic                   oe_q, lit;
    logic [SEG_WIDTH-1:0]   ram [NUM_DIGITS];
    logic [SHIFT_LEN-1:0]   seg_sr, com_sr, seg_load, com_load;
    logic [SEG_WIDTH-1:0]   seg_pat;
    logic [NUM_DIGITS-1:0]  com_pat;
    logic                   srclk, rclk, shift_step, shift_last, latch_last;

    shift595_serializer #(
        .SHIFT_LEN (SHIFT_LEN),
        .CLK_DIV   (CLK_DIV)
    ) u_serializer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (state_q == LOAD),
        .shifting   (state_q == SHIFT),
        .latching   (state_q == LATCH),
        .srclk      (srclk),
        .rclk       (rclk),
        .shift_step (shift_step),
        .shift_last (shift_last),
        .latch_last (latch_last)
    );

    // Out-of-range indices are dropped rather than aliased onto a real digit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                ram[i] <= '0;
            end
        end else if (wr_en && (wr_digit < WDW'(NUM_DIGITS))) begin
            ram[wr_digit[DW-1:0]] <= wr_segments;
        end
    end

    always_comb begin
        seg_pat = ram[digit_q];
        com_pat = NUM_DIGITS'(1) << digit_q;
        if (SEG_ACTIVE_LOW != 0) begin
            seg_pat = ~seg_pat;
        end
        if (COM_ACTIVE_LOW != 0) begin
            com_pat = ~com_pat;
        end
        seg_load = SHIFT_LEN'(seg_pat);
        com_load = SHIFT_LEN'(com_pat);
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        digit_d = digit_q;
        frame_d = 1'b0;
        case (state_q)
            IDLE:  if (enable) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: if (shift_last) state_d = LATCH;
            LATCH: begin
                if (latch_last) begin
                    state_d = HOLD;
                    h_d     = '0;
                end
            end
            HOLD: begin
                h_d = h_q + HW'(1);
                if (h_q == H_LAST) begin
                    h_d     = '0;
                    digit_d = (digit_q == D_LAST) ? '0 : digit_q + DW'(1);
                    frame_d = (digit_q == D_LAST);
                    state_d = enable ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SEGMENT_SCAN_PWM_EN
    always_comb begin
        lit = (state_d == HOLD) && ((32'(h_d) % PWM_PERIOD) < 32'(brightness));
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    always_comb begin
        lit = (state_d == HOLD);
    end
`endif

    // The chain vectors shift out MSB first and back-fill with zeros
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            digit_q <= '0;
            frame_q <= 1'b0;
            oe_q    <= 1'b1;
            seg_sr  <= '0;
            com_sr  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            oe_q    <= ~lit;
            if (state_q == LOAD) begin
                seg_sr <= seg_load;
                com_sr <= com_load;
            end else if (shift_step) begin
                seg_sr <= seg_sr << 1;
                com_sr <= com_sr << 1;
            end
        end
    end

    assign seg_ser    = seg_sr[SHIFT_LEN-1];
    assign com_ser    = com_sr[SHIFT_LEN-1];
    assign seg_srclk  = srclk;
    assign com_srclk  = srclk;
    assign seg_rclk   = rclk;
    assign com_rclk   = rclk;
    assign seg_oe     = oe_q;
    assign com_oe     = oe_q;
    assign frame_done = frame_q;

endmodule
